// File: rtl/legv8_pkg.sv
// Shared LEGv8 pipeline constants and types for hazard detection and forwarding.
package legv8_pkg;

    localparam logic [4:0] XZR = 5'd31;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b01;
    localparam logic [1:0] FWD_MEMWB   = 2'b10;

    // Per-stage bookkeeping for the instruction occupying EX, MEM or WB.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } stage_tag_t;

endpackage

// File: rtl/hazard_tag_pipe.sv
// Three-stage EX/MEM/WB tag shift register; a bubble loads an all-zero tag into EX.
module hazard_tag_pipe
    import legv8_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bubble_i,
    input  stage_tag_t id_tag_i,
    output stage_tag_t ex_tag_o,
    output stage_tag_t mem_tag_o,
    output stage_tag_t wb_tag_o
);

    stage_tag_t ex_q;
    stage_tag_t mem_q;
    stage_tag_t wb_q;

    // EX->MEM->WB always advances; only the ID->EX hop can be replaced by a NOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= bubble_i ? '0 : id_tag_i;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    assign ex_tag_o  = ex_q;
    assign mem_tag_o = mem_q;
    assign wb_tag_o  = wb_q;

endmodule

// File: rtl/decode_hazard_ctrl.sv
// LEGv8 decode-stage hazard unit: load-use stall, flush bubble, registered
// operand forwarding selects and a saturating stall counter.
module decode_hazard_ctrl
    import legv8_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        ex_flush,
    output logic        stall,
    output logic        id_bubble,
    output logic [1:0]  ex_fwd_a,
    output logic [1:0]  ex_fwd_b,
    output logic [15:0] stall_count
);

    stage_tag_t idTag;
    stage_tag_t exTag;
    stage_tag_t memTag;
    stage_tag_t wbTag;

    logic rs1Ex;
    logic rs2Ex;
    logic rs1Mem;
    logic rs2Mem;
    logic loadUse;

    logic [1:0]  fwdA_d;
    logic [1:0]  fwdA_q;
    logic [1:0]  fwdB_d;
    logic [1:0]  fwdB_q;
    logic [15:0] stallCount_d;
    logic [15:0] stallCount_q;

    // WB producers are covered by regfile write-through, so that tag is only carried along.
    logic unusedTagBits;
    assign unusedTagBits = ^{wbTag, memTag.mem_read};

    assign idTag = {id_valid, id_rd, id_reg_write, id_mem_read};

    hazard_tag_pipe u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .bubble_i  (id_bubble),
        .id_tag_i  (idTag),
        .ex_tag_o  (exTag),
        .mem_tag_o (memTag),
        .wb_tag_o  (wbTag)
    );

    always_comb begin
        rs1Ex  = id_use_rs1 && exTag.valid && exTag.reg_write
                 && (exTag.rd == id_rs1) && (id_rs1 != XZR);
        rs2Ex  = id_use_rs2 && exTag.valid && exTag.reg_write
                 && (exTag.rd == id_rs2) && (id_rs2 != XZR);
        rs1Mem = id_use_rs1 && memTag.valid && memTag.reg_write
                 && (memTag.rd == id_rs1) && (id_rs1 != XZR);
        rs2Mem = id_use_rs2 && memTag.valid && memTag.reg_write
                 && (memTag.rd == id_rs2) && (id_rs2 != XZR);

        loadUse   = id_valid && exTag.mem_read && (rs1Ex || rs2Ex);
        id_bubble = ex_flush || loadUse;
        stall     = loadUse && !ex_flush;
    end

    // EX match is checked first so the youngest producer wins over MEM.
    always_comb begin
        fwdA_d = FWD_REGFILE;
        fwdB_d = FWD_REGFILE;
        if (id_valid && !id_bubble) begin
            if (rs1Ex) begin
                fwdA_d = FWD_EXMEM;
            end else if (rs1Mem) begin
                fwdA_d = FWD_MEMWB;
            end
            if (rs2Ex) begin
                fwdB_d = FWD_EXMEM;
            end else if (rs2Mem) begin
                fwdB_d = FWD_MEMWB;
            end
        end
    end

    always_comb begin
        stallCount_d = stallCount_q;
        if (stall && (stallCount_q != 16'hFFFF)) begin
            stallCount_d = stallCount_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwdA_q       <= FWD_REGFILE;
            fwdB_q       <= FWD_REGFILE;
            stallCount_q <= 16'd0;
        end else begin
            fwdA_q       <= fwdA_d;
            fwdB_q       <= fwdB_d;
            stallCount_q <= stallCount_d;
        end
    end

    assign ex_fwd_a    = fwdA_q;
    assign ex_fwd_b    = fwdB_q;
    assign stall_count = stallCount_q;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Self-checking bench for decode_hazard_ctrl: directed pipeline scenarios plus
// randomized instruction streams against a history-based reference model.
module tb_decode_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  id_rd;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        ex_flush;
    logic        stall;
    logic        id_bubble;
    logic [1:0]  ex_fwd_a;
    logic [1:0]  ex_fwd_b;
    logic [15:0] stall_count;

    int errors = 0;
    int checks = 0;

    // Issued-instruction history: index 0 is the instruction now in EX, 1 in MEM, 2 in WB.
    typedef struct {
        bit       valid;
        bit [4:0] rd;
        bit       rw;
        bit       mr;
    } rec_t;

    rec_t     issued[$];
    bit [1:0] mFwdA;
    bit [1:0] mFwdB;
    int       mCount;

    always #5 clk = ~clk;

    decode_hazard_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .ex_flush     (ex_flush),
        .stall        (stall),
        .id_bubble    (id_bubble),
        .ex_fwd_a     (ex_fwd_a),
        .ex_fwd_b     (ex_fwd_b),
        .stall_count  (stall_count)
    );

    task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        rec_t empty;
        empty = '{valid: 1'b0, rd: 5'd0, rw: 1'b0, mr: 1'b0};
        issued = {};
        repeat (3) issued.push_back(empty);
        mFwdA  = 2'b00;
        mFwdB  = 2'b00;
        mCount = 0;
    endtask

    // Age of the youngest in-flight writer of src still needing a forward (1=EX, 2=MEM), 0 if none.
    function automatic int producerAge(input bit useSrc, input bit [4:0] src);
        if (!useSrc || src == 5'd31) return 0;
        for (int k = 0; k < 2; k++) begin
            if (issued[k].valid && issued[k].rw && issued[k].rd == src) return k + 1;
        end
        return 0;
    endfunction

    function automatic bit [1:0] ageToSel(input int age);
        if (age == 1) return 2'b01;
        if (age == 2) return 2'b10;
        return 2'b00;
    endfunction

    task automatic modelComb(output bit expStall, output bit expBub,
                             output bit [1:0] nextA, output bit [1:0] nextB);
        int  ageA;
        int  ageB;
        bit  hazard;
        ageA     = producerAge(id_use_rs1, id_rs1);
        ageB     = producerAge(id_use_rs2, id_rs2);
        hazard   = id_valid && issued[0].mr && (ageA == 1 || ageB == 1);
        expStall = hazard && !ex_flush;
        expBub   = hazard || ex_flush;
        nextA    = (expBub || !id_valid) ? 2'b00 : ageToSel(ageA);
        nextB    = (expBub || !id_valid) ? 2'b00 : ageToSel(ageB);
    endtask

    task automatic checkOutput();
        bit       expStall;
        bit       expBub;
        bit [1:0] nA;
        bit [1:0] nB;
        modelComb(expStall, expBub, nA, nB);
        checkVal("stall", stall, expStall);
        checkVal("id_bubble", id_bubble, expBub);
        checkVal("ex_fwd_a", ex_fwd_a, mFwdA);
        checkVal("ex_fwd_b", ex_fwd_b, mFwdB);
        checkVal("stall_count", stall_count, mCount[15:0]);
    endtask

    task automatic advanceModel();
        bit       expStall;
        bit       expBub;
        bit [1:0] nA;
        bit [1:0] nB;
        rec_t     r;
        modelComb(expStall, expBub, nA, nB);
        mFwdA = nA;
        mFwdB = nB;
        if (expStall && mCount < 65535) mCount++;
        if (expBub) r = '{valid: 1'b0, rd: 5'd0, rw: 1'b0, mr: 1'b0};
        else        r = '{valid: id_valid, rd: id_rd, rw: id_reg_write, mr: id_mem_read};
        issued.push_front(r);
        void'(issued.pop_back());
    endtask

    // One clock: compare mid-cycle, step the model on the edge, return just after it.
    task automatic applyStimulus();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        advanceModel();
        #1;
    endtask

    task automatic setInstr(input bit v, input bit [4:0] rs1, input bit [4:0] rs2,
                            input bit u1, input bit u2, input bit [4:0] rd,
                            input bit rw, input bit mr);
        id_valid     = v;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_use_rs1   = u1;
        id_use_rs2   = u2;
        id_rd        = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
    endtask

    task automatic drain();
        setInstr(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) applyStimulus();
    endtask

    function automatic bit [4:0] pickReg();
        int r;
        r = $urandom_range(4);
        return (r == 4) ? 5'd31 : r[4:0];
    endfunction

    initial begin
        rst_n    = 1'b0;
        ex_flush = 1'b0;
        setInstr(0, 0, 0, 0, 0, 0, 0, 0);
        modelReset();
        #1;
        checkVal("reset_count", stall_count, 16'd0);
        checkVal("reset_fwd_a", ex_fwd_a, 16'd0);
        checkVal("reset_fwd_b", ex_fwd_b, 16'd0);
        checkVal("reset_stall", stall, 16'd0);
        checkVal("reset_bubble", id_bubble, 16'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // LDUR X2,[X1] then ADD X3,X2,X4: one stall, then forward from MEM/WB.
        setInstr(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1);
        applyStimulus();
        setInstr(1, 5'd2, 5'd4, 1, 1, 5'd3, 1, 0);
        #1;
        checkVal("ldu_stall", stall, 16'd1);
        checkVal("ldu_bubble", id_bubble, 16'd1);
        applyStimulus();
        checkVal("ldu_count", stall_count, 16'd1);
        checkVal("ldu_stall_released", stall, 16'd0);
        applyStimulus();
        checkVal("ldu_fwd_a", ex_fwd_a, 16'd2);
        checkVal("ldu_fwd_b", ex_fwd_b, 16'd0);
        drain();

        // ADD X1,X2,X3 then SUB X5,X1,X1: both operands from EX/MEM.
        setInstr(1, 5'd2, 5'd3, 1, 1, 5'd1, 1, 0);
        applyStimulus();
        setInstr(1, 5'd1, 5'd1, 1, 1, 5'd5, 1, 0);
        #1;
        checkVal("exfwd_stall", stall, 16'd0);
        applyStimulus();
        checkVal("exfwd_a", ex_fwd_a, 16'd1);
        checkVal("exfwd_b", ex_fwd_b, 16'd1);
        drain();

        // ADD X1; ADD X1; ADD X6,X1,X7: youngest producer selected.
        setInstr(1, 5'd2, 5'd3, 1, 1, 5'd1, 1, 0);
        applyStimulus();
        applyStimulus();
        setInstr(1, 5'd1, 5'd7, 1, 1, 5'd6, 1, 0);
        applyStimulus();
        checkVal("youngest_fwd_a", ex_fwd_a, 16'd1);
        drain();

        // LDUR X31 then consumer of X31: zero register never hazards or forwards.
        setInstr(1, 5'd2, 5'd0, 1, 0, 5'd31, 1, 1);
        applyStimulus();
        setInstr(1, 5'd31, 5'd31, 1, 1, 5'd8, 1, 0);
        #1;
        checkVal("xzr_stall", stall, 16'd0);
        applyStimulus();
        checkVal("xzr_fwd_a", ex_fwd_a, 16'd0);
        checkVal("xzr_fwd_b", ex_fwd_b, 16'd0);
        drain();

        // Load-use hazard coinciding with a flush: flush wins, counter holds.
        setInstr(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1);
        applyStimulus();
        setInstr(1, 5'd2, 5'd4, 1, 1, 5'd3, 1, 0);
        ex_flush = 1'b1;
        #1;
        checkVal("flush_stall", stall, 16'd0);
        checkVal("flush_bubble", id_bubble, 16'd1);
        applyStimulus();
        ex_flush = 1'b0;
        checkVal("flush_count", stall_count, 16'd1);
        checkVal("flush_fwd_a", ex_fwd_a, 16'd0);
        drain();

        // ADD X1; LDUR X2,[X1]; ADD X3,X2,X4 with reset asserted during the stall.
        setInstr(1, 5'd2, 5'd3, 1, 1, 5'd1, 1, 0);
        applyStimulus();
        setInstr(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1);
        applyStimulus();
        setInstr(1, 5'd2, 5'd4, 1, 1, 5'd3, 1, 0);
        #1;
        checkVal("rst_pre_stall", stall, 16'd1);
        checkVal("rst_pre_fwd_a", ex_fwd_a, 16'd1);
        #1 rst_n = 1'b0;
        #1;
        modelReset();
        checkVal("rst_mid_count", stall_count, 16'd0);
        checkVal("rst_mid_fwd_a", ex_fwd_a, 16'd0);
        checkVal("rst_mid_fwd_b", ex_fwd_b, 16'd0);
        checkVal("rst_mid_stall", stall, 16'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checkVal("rst_post_stall", stall, 16'd0);
        applyStimulus();
        drain();

        // Random instruction stream over a small register set to provoke many matches.
        for (int i = 0; i < 3000; i++) begin
            setInstr(($urandom_range(7) != 0), pickReg(), pickReg(),
                     $urandom_range(1), $urandom_range(1), pickReg(),
                     ($urandom_range(3) != 0), ($urandom_range(2) == 0));
            ex_flush = ($urandom_range(9) == 0);
            applyStimulus();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
